// File: rtl/cpu6502_bus_pkg.sv
// Shared types for the cpu6502 memory-side bus controller: FSM encoding and
// the posted-write FIFO entry layout.
package cpu6502_bus_pkg;

  localparam int WBUF_ENTRY_W = 24;

  typedef enum logic [1:0] {
    BC_IDLE = 2'd0,
    BC_WR   = 2'd1,
    BC_RD   = 2'd2
  } bc_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wbuf_entry_t;

  function automatic wbuf_entry_t pack_entry(input logic [15:0] addr,
                                             input logic [7:0]  data);
    wbuf_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/bus_wbuf_fifo.sv
// Synchronous FIFO holding posted core writes; head is combinational from storage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module bus_wbuf_fifo
  import cpu6502_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = WBUF_ENTRY_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/cpu6502_bus_ctrl.sv
// Bus controller between the cpu6502 core and a req/ack memory port: posts
// writes through a FIFO and stalls reads until the FIFO drains and one read completes.
module cpu6502_bus_ctrl
  import cpu6502_bus_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int WBUF_AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        wbuf_empty,
  output logic        wbuf_overflow
);

  bc_state_t   state;
  bc_state_t   state_nxt;

  wbuf_entry_t push_entry;
  wbuf_entry_t head_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic [WBUF_AW:0] fifo_count;
  logic        fifo_pop;
  logic        last_entry;

  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [15:0] rd_req_addr;
  logic [7:0]  rd_data;
  logic        rd_match;
  logic        rd_consume;
  logic        rd_issue;
  logic        rd_done;

  assign push_entry = pack_entry(cpu_address, cpu_data_o);

  bus_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .AW    (WBUF_AW),
    .W     (WBUF_ENTRY_W)
  ) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .push     (cpu_write),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .head     (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign fifo_pop   = (state == BC_WR) && mem_ack;
  // Draining the last entry ends the burst unless a new write lands this cycle.
  assign last_entry = (fifo_count == (WBUF_AW+1)'(1)) && !cpu_write;

  assign rd_match   = rd_valid && (rd_addr == cpu_address);
  assign rd_consume = !cpu_write && rd_match;
  assign rd_issue   = (state == BC_IDLE) && (state_nxt == BC_RD);
  assign rd_done    = (state == BC_RD) && mem_ack;

  assign cpu_ready  = cpu_write || rd_match;
  assign cpu_data_i = rd_data;
  assign wbuf_empty = fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) state <= BC_IDLE;
    else       state <= state_nxt;
  end

  // A write seen in IDLE goes straight to WR so mem_req rises the next edge.
  always_comb begin
    state_nxt = state;
    case (state)
      BC_IDLE: begin
        if (!fifo_empty || cpu_write) state_nxt = BC_WR;
        else if (!rd_match)           state_nxt = BC_RD;
      end
      BC_WR: begin
        if (mem_ack && last_entry) state_nxt = BC_IDLE;
      end
      BC_RD: begin
        if (mem_ack) state_nxt = BC_IDLE;
      end
      default: state_nxt = BC_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (state)
      BC_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_entry.addr;
        mem_wdata = head_entry.data;
      end
      BC_RD: begin
        mem_req  = 1'b1;
        mem_addr = rd_req_addr;
      end
      default: ;
    endcase
  end

  // Issuing a read also discards any stale result left from a redirected fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid      <= 1'b0;
      rd_addr       <= 16'h0000;
      rd_req_addr   <= 16'h0000;
      rd_data       <= 8'h00;
      wbuf_overflow <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_req_addr <= cpu_address;
        rd_valid    <= 1'b0;
      end
      if (rd_consume) rd_valid <= 1'b0;
      if (rd_done) begin
        rd_data  <= mem_rdata;
        rd_addr  <= rd_req_addr;
        rd_valid <= 1'b1;
      end
      if (cpu_write && fifo_full && !fifo_pop) wbuf_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu6502_bus_ctrl.sv
// Directed bench for cpu6502_bus_ctrl with a variable-latency memory model.
module tb_cpu6502_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_write;
  logic [7:0]  cpu_data_o;
  logic [7:0]  cpu_data_i;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        wbuf_empty;
  logic        wbuf_overflow;

  cpu6502_bus_ctrl #(.WBUF_DEPTH(4), .WBUF_AW(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_address   (cpu_address),
    .cpu_write     (cpu_write),
    .cpu_data_o    (cpu_data_o),
    .cpu_data_i    (cpu_data_i),
    .cpu_ready     (cpu_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .wbuf_empty    (wbuf_empty),
    .wbuf_overflow (wbuf_overflow)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_lat waiting cycles; 0xD012 behaves like a
  // counter register that advances on every read.
  logic [7:0]  mem_arr [0:65535];
  int          ack_lat   = 0;
  bit          ack_block = 1'b0;
  bit          ack_force = 1'b0;
  int          wait_cnt  = 0;
  int          d012_reads = 0;
  logic [7:0]  io_base   = 8'h40;
  logic [23:0] wlog [$];

  assign mem_ack   = ack_force | (mem_req & !ack_block & (wait_cnt >= ack_lat));
  assign mem_rdata = (mem_addr == 16'hD012) ? 8'(io_base + d012_reads[7:0])
                                            : mem_arr[mem_addr];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_ack && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (mem_req && mem_ack && !mem_we && mem_addr == 16'hD012)
      d012_reads <= d012_reads + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    tick();
    reset       = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = 16'h0000;
    cpu_data_o  = 8'h00;
    ack_force   = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_ready) break;
    end
    chk(tag, cpu_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int r0;
    bit bad_order;
    bit early;
    logic [23:0] exp_burst [3];
    exp_burst[0] = 24'h01FD12;
    exp_burst[1] = 24'h01FC34;
    exp_burst[2] = 24'h01FB56;

    reset = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0000; cpu_data_o = 8'h00;
    mem_arr[16'h1234] <= 8'hA5;
    mem_arr[16'h0200] <= 8'h00;
    mem_arr[16'h0300] <= 8'h11;
    mem_arr[16'h0310] <= 8'h22;
    mem_arr[16'h4000] <= 8'h5A;

    // Read with immediate ack, plus reset values.
    ack_lat = 0; ack_block = 1'b0;
    start_reset();
    cpu_address = 16'h1234;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_data_i", cpu_data_i, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_wbuf_empty", wbuf_empty, 1);
    chk("rst_overflow", wbuf_overflow, 0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rd0_req_c0", mem_req, 0);
    @(negedge clk);
    chk("rd0_req_c1", mem_req, 1);
    chk("rd0_we_c1", mem_we, 0);
    chk("rd0_addr_c1", mem_addr, 16'h1234);
    chk("rd0_ready_c1", cpu_ready, 0);
    @(negedge clk);
    chk("rd0_ready_c2", cpu_ready, 1);
    chk("rd0_data_c2", cpu_data_i, 8'hA5);

    // Three-write stack push burst, ack latency 3.
    ack_lat = 3;
    start_reset();
    base = wlog.size();
    reset = 1'b0; cpu_write = 1'b1; cpu_address = 16'h01FD; cpu_data_o = 8'h12;
    @(negedge clk);
    chk("burst_req_w0", mem_req, 0);
    chk("burst_ready_w0", cpu_ready, 1);
    tick(); cpu_address = 16'h01FC; cpu_data_o = 8'h34;
    @(negedge clk);
    chk("burst_req_w1", mem_req, 1);
    chk("burst_we_w1", mem_we, 1);
    chk("burst_addr_w1", mem_addr, 16'h01FD);
    chk("burst_wdata_w1", mem_wdata, 8'h12);
    tick(); cpu_address = 16'h01FB; cpu_data_o = 8'h56;
    tick(); cpu_write = 1'b0; cpu_address = 16'h0300;
    for (int i = 0; i < 60 && wlog.size() < base + 3; i++) @(negedge clk);
    chk("burst_count", wlog.size() - base, 3);
    for (int k = 0; k < 3; k++)
      if (wlog.size() > base + k) chk($sformatf("burst_entry%0d", k), wlog[base+k], exp_burst[k]);
    chk("burst_empty", wbuf_empty, 1);
    chk("burst_overflow", wbuf_overflow, 0);

    // Posted write then read of the same location.
    ack_lat = 2;
    start_reset();
    base = wlog.size();
    reset = 1'b0; cpu_write = 1'b1; cpu_address = 16'h0200; cpu_data_o = 8'h77;
    tick(); cpu_write = 1'b0;
    bad_order = 1'b0; early = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && wlog.size() == base) bad_order = 1'b1;
      if (cpu_ready && wlog.size() == base) early = 1'b1;
      if (cpu_ready) break;
    end
    chk("raw_ready", cpu_ready, 1);
    chk("raw_data", cpu_data_i, 8'h77);
    chk("raw_read_before_write", bad_order, 0);
    chk("raw_ready_during_drain", early, 0);
    chk("raw_write_count", wlog.size() - base, 1);

    // Overflow with memory stalled.
    ack_block = 1'b1;
    start_reset();
    base = wlog.size();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      reset = 1'b0; cpu_write = 1'b1;
      cpu_address = 16'h0300 + 16'(i); cpu_data_o = 8'hA0 + 8'(i);
      @(negedge clk);
      if (i == 4) chk("ovf_before_drop", wbuf_overflow, 0);
    end
    tick(); cpu_write = 1'b0; cpu_address = 16'h0310;
    @(negedge clk);
    chk("ovf_set", wbuf_overflow, 1);
    chk("ovf_not_empty", wbuf_empty, 0);
    chk("ovf_stalled_req", mem_req, 1);
    tick(); ack_block = 1'b0; ack_lat = 1;
    for (int i = 0; i < 60 && wlog.size() < base + 4; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("ovf_drain_count", wlog.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (wlog.size() > base + k)
        chk($sformatf("ovf_entry%0d", k), wlog[base+k], {16'h0300 + 16'(k), 8'hA0 + 8'(k)});
    chk("ovf_sticky", wbuf_overflow, 1);

    // Repeated I/O read must hit memory twice.
    ack_lat = 1;
    start_reset();
    r0 = d012_reads;
    reset = 1'b0; cpu_address = 16'hD012;
    wait_ready("io_ready1");
    chk("io_data1", cpu_data_i, 8'(8'h40 + r0));
    wait_ready("io_ready2");
    chk("io_data2", cpu_data_i, 8'(8'h41 + r0));
    chk("io_read_count", d012_reads - r0, 2);

    // Reset during an outstanding read; late ack ignored.
    ack_block = 1'b1;
    start_reset();
    base = wlog.size();
    reset = 1'b0; cpu_address = 16'h4000;
    @(negedge clk);
    @(negedge clk);
    chk("rrst_req_before", mem_req, 1);
    chk("rrst_addr_before", mem_addr, 16'h4000);
    tick(); reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rrst_req_after", mem_req, 0);
    chk("rrst_ready_after", cpu_ready, 0);
    tick(); ack_force = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rrst_late_ack_ready", cpu_ready, 0);
    tick(); ack_force = 1'b0; ack_block = 1'b0; ack_lat = 1;
    @(negedge clk);
    chk("rrst_late_ack_data", cpu_data_i, 0);
    chk("rrst_resume_req", mem_req, 1);
    wait_ready("rrst_resume_ready");
    chk("rrst_resume_data", cpu_data_i, 8'h5A);
    chk("rrst_no_writes", wlog.size() - base, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
